// File: rtl/ntt_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_stream_fifo
//  Description : First-word-fall-through stream FIFO for NTT coefficients.
//                Each word is a 64-bit coefficient plus an end-of-transfer
//                flag in the top bit. It provides registered full, empty
//                and count flags, and a mirrored peek port.
//  Revision    : 1.0 - initial release
// ============================================================================
module ntt_stream_fifo #(
    parameter int DATA_WIDTH = 65,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    output logic                  if_full_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_peek_dout,
    output logic                  if_peek_empty_n,
    output logic [ADDR_WIDTH:0]   if_count
);

    localparam logic [ADDR_WIDTH:0]   C_DEPTH   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   C_CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);

    // Storage is intentionally not reset. A word is visible only while
    // empty_n_q is set, so stale contents can never leak out.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  full_n_q, full_n_d;
    logic                  empty_n_q, empty_n_d;

    logic                  w_wr_accept;
    logic                  w_rd_accept;

    // Handshakes qualify on the registered flags. Simultaneous requests at
    // full therefore accept only the read. At empty, they accept only the write.
    assign w_wr_accept = if_write & full_n_q;
    assign w_rd_accept = if_read  & empty_n_q;

    // Next-state: pointer advance, occupancy update and flags derived from the new count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr_accept) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (w_rd_accept) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end
        case ({w_wr_accept, w_rd_accept})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase
        empty_n_d = (count_d != '0);
        full_n_d  = (count_d != C_DEPTH);
    end

    // Control state. Full_n holds low through reset and rises on the first live edge
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_n_q  <= 1'b0;
            empty_n_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
        end
    end

    // Data storage, written only on an accepted write
    always_ff @(posedge ap_clk) begin
        if (w_wr_accept) begin
            mem_q[wr_ptr_q] <= if_din;
        end
    end

    // The head word falls through combinationally and is forced to zero while empty
    assign if_dout         = empty_n_q ? mem_q[rd_ptr_q] : '0;
    assign if_empty_n      = empty_n_q;
    assign if_full_n       = full_n_q;
    assign if_count        = count_q;
    assign if_peek_dout    = if_dout;
    assign if_peek_empty_n = empty_n_q;

endmodule
`default_nettype wire

// File: tb/tb_ntt_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ntt_stream_fifo
//  Description : Self-checking bench for ntt_stream_fifo. It uses a
//                queue-based reference model, a vector table and directed
//                corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_stream_fifo;

    localparam int DW    = 65;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic [DW-1:0] if_din;
    logic          if_write;
    logic          if_full_n;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic          if_read;
    logic [DW-1:0] if_peek_dout;
    logic          if_peek_empty_n;
    logic [AW:0]   if_count;

    ntt_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .if_din          (if_din),
        .if_write        (if_write),
        .if_full_n       (if_full_n),
        .if_dout         (if_dout),
        .if_empty_n      (if_empty_n),
        .if_read         (if_read),
        .if_peek_dout    (if_peek_dout),
        .if_peek_empty_n (if_peek_empty_n),
        .if_count        (if_count)
    );

    always #5 ap_clk = ~ap_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the stored words in order, plus the space flag
    logic [DW-1:0] m_q [$];
    logic          m_full_n = 1'b0;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        int            cnt;
        logic          en;
        logic          fn;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_check(input string tag);
        logic [DW-1:0] exp_dout;
        exp_dout = (m_q.size() != 0) ? m_q[0] : '0;
        chk({tag, ".count"},   DW'(if_count),        DW'(m_q.size()));
        chk({tag, ".empty_n"}, DW'(if_empty_n),      DW'(m_q.size() != 0));
        chk({tag, ".full_n"},  DW'(if_full_n),       DW'(m_full_n));
        chk({tag, ".dout"},    if_dout,              exp_dout);
        chk({tag, ".pdout"},   if_peek_dout,         exp_dout);
        chk({tag, ".pempty"},  DW'(if_peek_empty_n), DW'(m_q.size() != 0));
    endtask

    // Apply one cycle of requests, advance the model by the handshake rules, then compare
    task automatic step(input logic wr, input logic rd, input logic [DW-1:0] din, input string tag);
        bit wr_ok, rd_ok, live;
        if_write = wr;
        if_read  = rd;
        if_din   = din;
        live  = (ap_rst_n === 1'b1);
        wr_ok = live && wr && m_full_n;
        rd_ok = live && rd && (m_q.size() != 0);
        @(posedge ap_clk);
        #1;
        if (live) begin
            if (rd_ok) void'(m_q.pop_front());
            if (wr_ok) m_q.push_back(din);
            m_full_n = (m_q.size() != DEPTH);
        end
        model_check(tag);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_full_n = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 65'h0_0000000000000001, 1, 1'b1, 1'b1, 65'h0_0000000000000001};
        tbl[1] = '{1'b1, 1'b0, 65'h0_0000000000000002, 2, 1'b1, 1'b1, 65'h0_0000000000000001};
        tbl[2] = '{1'b0, 1'b1, 65'h0_FFFFFFFFFFFFFFFF, 1, 1'b1, 1'b1, 65'h0_0000000000000002};
        tbl[3] = '{1'b1, 1'b1, 65'h0_0000000000000003, 1, 1'b1, 1'b1, 65'h0_0000000000000003};
        tbl[4] = '{1'b0, 1'b1, 65'h0_0000000000000000, 0, 1'b0, 1'b1, 65'h0_0000000000000000};
        tbl[5] = '{1'b0, 1'b1, 65'h0_0000000000000000, 0, 1'b0, 1'b1, 65'h0_0000000000000000};
        tbl[6] = '{1'b1, 1'b1, 65'h0_0000000000000007, 1, 1'b1, 1'b1, 65'h0_0000000000000007};
        tbl[7] = '{1'b1, 1'b0, 65'h1_00000000ABCD0000, 2, 1'b1, 1'b1, 65'h0_0000000000000007};
        tbl[8] = '{1'b0, 1'b1, 65'h0_0000000000000000, 1, 1'b1, 1'b1, 65'h1_00000000ABCD0000};
        tbl[9] = '{1'b0, 1'b1, 65'h0_0000000000000000, 0, 1'b0, 1'b1, 65'h0_0000000000000000};

        // Reset values must appear before any clock edge
        ap_rst_n = 1'b0;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_din   = '0;
        #1;
        model_check("rst_async");
        step(1'b1, 1'b0, 65'hDEAD, "rst_hold0");
        step(1'b0, 1'b0, '0, "rst_hold1");

        // A write presented on the first live edge is rejected, because full_n is still low
        ap_rst_n = 1'b1;
        step(1'b1, 1'b0, 65'hDEAD, "rst_first_edge");
        chk("rst_first.full_n", DW'(if_full_n), DW'(1'b1));
        chk("rst_first.count",  DW'(if_count),  DW'(0));

        // Vector table
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].din, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.cnt", i),  DW'(if_count),   DW'(tbl[i].cnt));
            chk($sformatf("tbl%0d.en", i),   DW'(if_empty_n), DW'(tbl[i].en));
            chk($sformatf("tbl%0d.fn", i),   DW'(if_full_n),  DW'(tbl[i].fn));
            chk($sformatf("tbl%0d.dout", i), if_dout,         tbl[i].dout);
        end

        // Fill to full, then an ignored overflow write
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i), "fill");
        chk("full.full_n", DW'(if_full_n), DW'(1'b0));
        chk("full.count",  DW'(if_count),  DW'(32));
        step(1'b1, 1'b0, 65'hDEAD, "overflow");
        chk("overflow.count", DW'(if_count), DW'(32));
        chk("overflow.dout",  if_dout,       DW'(0));
        // Simultaneous read+write at full: only the read is accepted
        step(1'b1, 1'b1, 65'h99, "full_rw");
        chk("full_rw.count", DW'(if_count), DW'(31));
        chk("full_rw.dout",  if_dout,       DW'(1));
        for (int i = 1; i < DEPTH; i++) begin
            chk($sformatf("drain%0d", i), if_dout, DW'(i));
            step(1'b0, 1'b1, '0, "drain");
        end
        chk("drained.empty_n", DW'(if_empty_n), DW'(1'b0));

        // Continuous streaming over 100 words, with the flag on the last word
        step(1'b1, 1'b0, DW'(0), "stream0");
        for (int i = 1; i < 100; i++) begin
            chk($sformatf("stream_out%0d", i - 1), if_dout, DW'(i - 1));
            step(1'b1, 1'b1, (i == 99) ? {1'b1, 64'(i)} : DW'(i), "stream");
        end
        chk("stream_out99", if_dout, {1'b1, 64'd99});
        step(1'b0, 1'b1, '0, "stream_end");

        // Randomized traffic, with phases biased toward full, toward empty, and balanced
        for (int i = 0; i < 3000; i++) begin
            int pw, pr;
            case ((i / 150) % 3)
                0:       begin pw = 85; pr = 25; end
                1:       begin pw = 25; pr = 85; end
                default: begin pw = 60; pr = 60; end
            endcase
            step(1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < pr),
                 {1'($urandom_range(0, 1)), $urandom, $urandom}, "rand");
        end

        // Reset mid-operation with ten words stored
        while (m_q.size() != 0) step(1'b0, 1'b1, '0, "pre_drain");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DW'(100 + i), "pre_rst");
        chk("pre_rst.count", DW'(if_count), DW'(10));
        #2;
        ap_rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst.count",   DW'(if_count),   DW'(0));
        chk("mid_rst.empty_n", DW'(if_empty_n), DW'(0));
        chk("mid_rst.full_n",  DW'(if_full_n),  DW'(0));
        chk("mid_rst.dout",    if_dout,         DW'(0));
        model_check("mid_rst");
        step(1'b0, 1'b0, '0, "mid_rst_hold");
        ap_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, '0, "post_rst");
            chk("post_rst.empty_n", DW'(if_empty_n), DW'(0));
            chk("post_rst.dout",    if_dout,         DW'(0));
        end
        step(1'b1, 1'b0, 65'h1_0123456789ABCDEF, "post_rst_wr");
        chk("post_rst_wr.dout", if_dout, 65'h1_0123456789ABCDEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ntt_stream_fifo.md
NTT_STREAM_FIFO -- requirements
Module: ntt_stream_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 65, word width: bits [63:0] coefficient, bit [64] end-of-transfer flag.
REQ-002 Parameter DEPTH, default 32, storage words; power of two, minimum 4.
REQ-003 Parameter ADDR_WIDTH, default 5, equal to log2(DEPTH).
REQ-004 ap_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 ap_rst_n  input  1  asynchronous, active-low reset.
REQ-006 if_din  input  DATA_WIDTH  write data from the producer.
REQ-007 if_write  input  1  write request.
REQ-008 if_full_n  output  1  high = space available.
REQ-009 if_dout  output  DATA_WIDTH  head word, valid while if_empty_n=1.
REQ-010 if_empty_n  output  1  high = head word valid.
REQ-011 if_read  input  1  read request (pop head).
REQ-012 if_peek_dout  output  DATA_WIDTH  copy of if_dout for the consumer's non-consuming peek port.
REQ-013 if_peek_empty_n  output  1  copy of if_empty_n.
REQ-014 if_count  output  ADDR_WIDTH+1  number of stored words, 0..DEPTH.

Function
REQ-015 Write accepted in a cycle iff if_write=1 and if_full_n=1; otherwise if_din ignored, no state change from the write.
REQ-016 Read accepted in a cycle iff if_read=1 and if_empty_n=1; read while empty ignored, no underflow.
REQ-017 First-word-fall-through: if_dout presents the oldest word without a read; an accepted read advances to the next word on the following edge.
REQ-018 Write-to-visible latency 1 cycle: word accepted at edge N into an empty FIFO gives if_empty_n=1 and if_dout=that word after edge N.
REQ-019 if_full_n, if_empty_n and if_count registered, all updated on the same edge as the accepted operation.
REQ-020 Accepted write only: count+1; accepted read only: count-1; both: count unchanged, data order preserved.
REQ-021 At count=DEPTH: if_full_n=0; a simultaneous read and write accepts only the read (full_n sampled before the edge); count becomes DEPTH-1.
REQ-022 At count=0: simultaneous read and write accepts only the write; count becomes 1.
REQ-023 Read/write pointers ADDR_WIDTH bits, wrap modulo DEPTH without gap or duplicate.
REQ-024 Data passes bit-exact, including bit [64]; no reordering, loss or duplication.
REQ-025 if_peek_dout/if_peek_empty_n equal if_dout/if_empty_n every cycle; no peek input exists, so peek never consumes a word.
REQ-026 if_empty_n = (count != 0); if_full_n = (count != DEPTH).

Reset
REQ-027 ap_rst_n=0 immediately, independent of ap_clk: if_count=0, if_empty_n=0, if_full_n=0, if_dout=0, pointers=0.
REQ-028 if_full_n rises to 1 on the first ap_clk edge with ap_rst_n=1; writes presented before that edge are not accepted.
REQ-029 Reset mid-operation discards all stored words; no stale word appears on if_dout after reset release.

Verification
REQ-030 Reset, then write 0x0_0000000000000001 for 1 cycle -> if_empty_n=1, if_dout=0x0_0000000000000001, if_count=1 one edge later.
REQ-031 Write 32 words 0..31 with if_read=0 -> if_full_n=0 after 32nd edge, if_count=32; 33rd write value 0xDEAD ignored; reads return 0..31 in order then if_empty_n=0.
REQ-032 Full FIFO, if_write=1 and if_read=1 same cycle -> head 0 popped, new word not stored, if_count=31.
REQ-033 Empty FIFO, if_write=1 (value 7) and if_read=1 same cycle -> if_count=1, if_dout=7, no underflow.
REQ-034 Continuous write+read for 100 words, bit [64]=1 on word 99 -> output order 0..99, flag only on word 99, pointers wrap 3 times cleanly, if_peek_dout tracks if_dout throughout.
REQ-035 Assert ap_rst_n=0 asynchronously with if_count=10 -> outputs at reset values before next edge; after release if_empty_n stays 0 until a new write.
